// File: rtl/tmr0_controller_if.sv
// tmr0_controller_if: SFR, count-source and WDT signals of the Timer0 sequencer (master = core side, slave = timer)
interface tmr0_controller_if;
  logic       q_tick;
  logic       t0cki;
  logic       option_wr_en;
  logic [7:0] option_in;
  logic [7:0] option_out;
  logic       tmr0_wr_en;
  logic [7:0] tmr0_in;
  logic [7:0] tmr0_out;
  logic       wdt_tick;
  logic       wdt_clr;
  logic       wdt_ovf_tick;
  logic       t0if_set;
  modport master (
    output q_tick, t0cki, option_wr_en, option_in, tmr0_wr_en, tmr0_in, wdt_tick, wdt_clr,
    input  option_out, tmr0_out, wdt_ovf_tick, t0if_set
  );
  modport slave (
    input  q_tick, t0cki, option_wr_en, option_in, tmr0_wr_en, tmr0_in, wdt_tick, wdt_clr,
    output option_out, tmr0_out, wdt_ovf_tick, t0if_set
  );
endinterface

// File: rtl/tmr0_controller.sv
// tmr0_controller: Timer0/OPTION/shared-prescaler sequencer; ports clk, rst (sync, active-high), bus (tmr0_controller_if.slave)
module tmr0_controller #(
  parameter logic [7:0] OPTION_RESET   = 8'hFF,
  parameter logic [7:0] TMR0_RESET     = 8'h00,
  parameter int         SYNC_STAGES    = 2,
  parameter int         INHIBIT_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  tmr0_controller_if.slave bus
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 2);
  typedef enum logic {RUN, INH} state_t;
  state_t                 st_q;
  logic [IW-1:0]          inh_q;
  logic [7:0]             opt_q, tmr0_q, ps_q, ps_d, mask_t, mask_w;
  logic [SYNC_STAGES:0]   sync_q;
  logic                   t0if_q, wovf_q, wovf_d;
  logic                   psa, rise, fall, src, ps_clr, inc_ev, inc;
  assign psa    = opt_q[3];
  // top sync_q bit is the previous synchronised sample, used only for edge detection
  assign rise   = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
  assign fall   = ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES];
  assign src    = opt_q[5] ? (opt_q[4] ? fall : rise) : bus.q_tick;
  assign mask_t = 8'((9'd2 << opt_q[2:0]) - 9'd1);
  assign mask_w = 8'((9'd1 << opt_q[2:0]) - 9'd1);
  assign ps_clr = (psa ? bus.wdt_clr : bus.tmr0_wr_en) | (bus.option_wr_en & (bus.option_in[3] != psa));
  assign ps_d   = ps_clr ? 8'h00 : (psa ? bus.wdt_tick : src) ? ps_q + 8'h01 : ps_q;
  // a prescaled event fires on the count that wraps the selected low bits back to zero
  assign inc_ev = psa ? src : src & ~ps_clr & ((ps_q & mask_t) == mask_t);
  assign inc    = inc_ev & (st_q == RUN);
  assign wovf_d = bus.wdt_tick & ~bus.wdt_clr & (~psa | (~ps_clr & ((ps_q & mask_w) == mask_w)));
  always_ff @(posedge clk) begin
    if (rst) begin
      opt_q  <= OPTION_RESET;
      tmr0_q <= TMR0_RESET;
      ps_q   <= '0;
      sync_q <= '0;
      inh_q  <= '0;
      st_q   <= RUN;
      t0if_q <= 1'b0;
      wovf_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-1:0], bus.t0cki};
      ps_q   <= ps_d;
      wovf_q <= wovf_d;
      if (bus.option_wr_en) opt_q <= bus.option_in;
      if (bus.tmr0_wr_en) begin
        st_q  <= INH;
        inh_q <= IW'(INHIBIT_CYCLES);
      end else if (st_q == INH && bus.q_tick) begin
        inh_q <= inh_q - IW'(1);
        st_q  <= (inh_q == IW'(1)) ? RUN : INH;
      end
      tmr0_q <= bus.tmr0_wr_en ? bus.tmr0_in : inc ? tmr0_q + 8'h01 : tmr0_q;
      t0if_q <= ~bus.tmr0_wr_en & inc & (tmr0_q == 8'hFF);
    end
  end
  assign bus.option_out   = opt_q;
  assign bus.tmr0_out     = tmr0_q;
  assign bus.t0if_set     = t0if_q;
  assign bus.wdt_ovf_tick = wovf_q;
endmodule

// File: tb/tb_tmr0_controller.sv
// tb_tmr0_controller: directed vector table plus hand sequences for T0CKI edges and reset
module tb_tmr0_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [7:0] exp_t;
  tmr0_controller_if bus ();
  tmr0_controller dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic       ow;
    logic [7:0] od;
    logic       tw;
    logic [7:0] td;
    logic       qt, wt, wc;
    logic [7:0] e_opt, e_tmr;
    logic       e_t0if, e_wovf;
  } vec_t;
  vec_t vq[$];
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic add(input logic ow, input logic [7:0] od, input logic tw, input logic [7:0] td,
                     input logic qt, input logic wt, input logic wc, input logic [7:0] e_opt,
                     input logic [7:0] e_tmr, input logic e_t0if, input logic e_wovf);
    vq.push_back('{ow, od, tw, td, qt, wt, wc, e_opt, e_tmr, e_t0if, e_wovf});
  endtask
  task automatic apply(input vec_t v, input string tag);
    bus.option_wr_en = v.ow; bus.option_in = v.od;
    bus.tmr0_wr_en = v.tw;   bus.tmr0_in = v.td;
    bus.q_tick = v.qt; bus.wdt_tick = v.wt; bus.wdt_clr = v.wc;
    @(posedge clk); #1;
    bus.option_wr_en = 1'b0; bus.tmr0_wr_en = 1'b0;
    bus.q_tick = 1'b0; bus.wdt_tick = 1'b0; bus.wdt_clr = 1'b0;
    chk({tag, " option_out"}, bus.option_out, v.e_opt);
    chk({tag, " tmr0_out"}, bus.tmr0_out, v.e_tmr);
    chk({tag, " t0if_set"}, {7'd0, bus.t0if_set}, {7'd0, v.e_t0if});
    chk({tag, " wdt_ovf_tick"}, {7'd0, bus.wdt_ovf_tick}, {7'd0, v.e_wovf});
  endtask
  task automatic pin_phase(input logic val, input logic counts);
    bus.t0cki = val;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (counts && k == 3) exp_t++;
      chk($sformatf("t0cki=%0b clk%0d tmr0_out", val, k), bus.tmr0_out, exp_t);
      chk($sformatf("t0cki=%0b clk%0d t0if_set", val, k), {7'd0, bus.t0if_set}, 8'd0);
    end
  endtask
  initial begin
    bus.q_tick = 0; bus.t0cki = 0; bus.option_wr_en = 0; bus.option_in = 0;
    bus.tmr0_wr_en = 0; bus.tmr0_in = 0; bus.wdt_tick = 0; bus.wdt_clr = 0;
    add(0,8'h00,0,8'h00,0,0,0, 8'hFF,8'h00,0,0);
    add(1,8'h00,0,8'h00,0,0,0, 8'h00,8'h00,0,0);
    add(0,8'h00,1,8'hFE,0,0,0, 8'h00,8'hFE,0,0);
    add(0,8'h00,0,8'h00,1,0,0, 8'h00,8'hFE,0,0);
    add(0,8'h00,0,8'h00,1,0,0, 8'h00,8'hFE,0,0);
    add(0,8'h00,0,8'h00,1,0,0, 8'h00,8'hFE,0,0);
    add(0,8'h00,0,8'h00,1,0,0, 8'h00,8'hFF,0,0);
    add(0,8'h00,0,8'h00,1,0,0, 8'h00,8'hFF,0,0);
    add(0,8'h00,0,8'h00,1,0,0, 8'h00,8'h00,1,0);
    add(0,8'h00,0,8'h00,0,0,0, 8'h00,8'h00,0,0);
    add(1,8'h08,0,8'h00,0,0,0, 8'h08,8'h00,0,0);
    add(0,8'h00,0,8'h00,1,0,0, 8'h08,8'h01,0,0);
    add(0,8'h00,0,8'h00,1,0,0, 8'h08,8'h02,0,0);
    add(0,8'h00,0,8'h00,0,1,0, 8'h08,8'h02,0,1);
    add(0,8'h00,0,8'h00,0,1,0, 8'h08,8'h02,0,1);
    add(0,8'h00,0,8'h00,0,1,1, 8'h08,8'h02,0,0);
    add(1,8'h0B,0,8'h00,0,0,0, 8'h0B,8'h02,0,0);
    for (int i = 0; i < 8; i++) add(0,8'h00,0,8'h00,0,1,0, 8'h0B,8'h02,0,(i == 7));
    add(0,8'h00,1,8'hFF,0,0,0, 8'h0B,8'hFF,0,0);
    add(0,8'h00,0,8'h00,1,0,0, 8'h0B,8'hFF,0,0);
    add(0,8'h00,0,8'h00,1,0,0, 8'h0B,8'hFF,0,0);
    add(0,8'h00,1,8'h10,1,0,0, 8'h0B,8'h10,0,0);
    add(0,8'h00,0,8'h00,0,0,0, 8'h0B,8'h10,0,0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("vec%0d", i));
    apply('{1,8'h28,0,8'h00,0,0,0, 8'h28,8'h10,0,0}, "opt28");
    apply('{0,8'h00,0,8'h00,1,0,0, 8'h28,8'h10,0,0}, "opt28 qt1");
    apply('{0,8'h00,0,8'h00,1,0,0, 8'h28,8'h10,0,0}, "opt28 qt2");
    exp_t = 8'h10;
    repeat (3) begin pin_phase(1'b1, 1'b1); pin_phase(1'b0, 1'b0); end
    chk("rising total", bus.tmr0_out, 8'h13);
    apply('{1,8'h38,0,8'h00,0,0,0, 8'h38,8'h13,0,0}, "opt38");
    repeat (3) begin pin_phase(1'b1, 1'b0); pin_phase(1'b0, 1'b1); end
    chk("falling total", bus.tmr0_out, 8'h16);
    apply('{1,8'h00,0,8'h00,0,0,0, 8'h00,8'h16,0,0}, "pre-rst opt");
    apply('{0,8'h00,0,8'h00,1,0,0, 8'h00,8'h16,0,0}, "pre-rst qt1");
    apply('{0,8'h00,0,8'h00,1,0,0, 8'h00,8'h17,0,0}, "pre-rst qt2");
    apply('{0,8'h00,0,8'h00,1,0,0, 8'h00,8'h17,0,0}, "pre-rst qt3");
    rst = 1'b1;
    apply('{0,8'h00,0,8'h00,0,0,0, 8'hFF,8'h00,0,0}, "mid rst");
    rst = 1'b0;
    apply('{1,8'h09,0,8'h00,0,0,0, 8'h09,8'h00,0,0}, "post-rst opt09");
    apply('{0,8'h00,0,8'h00,0,1,0, 8'h09,8'h00,0,0}, "post-rst wt1");
    apply('{0,8'h00,0,8'h00,0,1,0, 8'h09,8'h00,0,1}, "post-rst wt2");
    apply('{1,8'h00,0,8'h00,0,0,0, 8'h00,8'h00,0,0}, "post-rst opt00");
    apply('{0,8'h00,0,8'h00,1,0,0, 8'h00,8'h00,0,0}, "post-rst qt1");
    apply('{0,8'h00,0,8'h00,1,0,0, 8'h00,8'h01,0,0}, "post-rst qt2");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
